// File: rtl/uart_avmm_master.sv
// Avalon-MM initiator for the UART register slave: turns one command into one
// read or write strobe, waits out waitrequest (with optional timeout) and returns one response.
module uart_avmm_master #(
  parameter int ADDR_W         = 3,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [ADDR_W-1:0] cmd_address_i,
  input  logic [31:0]       cmd_writedata_i,
  input  logic [3:0]        cmd_byteenable_i,
  output logic              rsp_valid_o,
  output logic              rsp_write_o,
  output logic [31:0]       rsp_readdata_o,
  output logic              rsp_timeout_o,
  output logic              busy_o,
  output logic              avmm_write_o,
  output logic              avmm_read_o,
  output logic [ADDR_W-1:0] avmm_address_o,
  output logic [31:0]       avmm_writedata_o,
  output logic [3:0]        avmm_byteenable_o,
  input  logic              avmm_waitrequest_i,
  input  logic [31:0]       avmm_readdata_i
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX       = '1;
  localparam bit               TIMEOUT_EN    = (TIMEOUT_CYCLES != 0);

  state_t           state;
  logic [CNT_W-1:0] stall_cnt;

  assign busy_o = (state != IDLE);

  // RESP always sits between two ACCESS phases, which together with the
  // one-cycle ready recovery guarantees two strobe-low cycles between accesses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      stall_cnt         <= '0;
      cmd_ready_o       <= 1'b0;
      rsp_valid_o       <= 1'b0;
      rsp_write_o       <= 1'b0;
      rsp_readdata_o    <= '0;
      rsp_timeout_o     <= 1'b0;
      avmm_write_o      <= 1'b0;
      avmm_read_o       <= 1'b0;
      avmm_address_o    <= '0;
      avmm_writedata_o  <= '0;
      avmm_byteenable_o <= '0;
    end else begin
      rsp_valid_o <= 1'b0;
      unique case (state)
        IDLE: begin
          cmd_ready_o <= 1'b1;
          if (cmd_valid_i && cmd_ready_o) begin
            cmd_ready_o       <= 1'b0;
            state             <= ACCESS;
            stall_cnt         <= '0;
            avmm_write_o      <= cmd_write_i;
            avmm_read_o       <= !cmd_write_i;
            avmm_address_o    <= cmd_address_i;
            avmm_writedata_o  <= cmd_write_i ? cmd_writedata_i : 32'h0;
            avmm_byteenable_o <= cmd_write_i ? cmd_byteenable_i : 4'hF;
          end
        end
        ACCESS: begin
          // A slave that releases waitrequest on the limit cycle still wins.
          if (!avmm_waitrequest_i) begin
            avmm_write_o   <= 1'b0;
            avmm_read_o    <= 1'b0;
            rsp_valid_o    <= 1'b1;
            rsp_write_o    <= avmm_write_o;
            rsp_readdata_o <= avmm_read_o ? avmm_readdata_i : 32'h0;
            rsp_timeout_o  <= 1'b0;
            state          <= RESP;
          end else if (TIMEOUT_EN && (stall_cnt == TIMEOUT_LIMIT)) begin
            avmm_write_o   <= 1'b0;
            avmm_read_o    <= 1'b0;
            rsp_valid_o    <= 1'b1;
            rsp_write_o    <= avmm_write_o;
            rsp_readdata_o <= 32'h0;
            rsp_timeout_o  <= 1'b1;
            state          <= RESP;
          end else if (stall_cnt != CNT_MAX) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          cmd_ready_o <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  a_one_strobe: assert property (@(posedge clk) !(avmm_read_o && avmm_write_o));

  a_strobe_only_in_access: assert property (@(posedge clk) disable iff (reset)
    (state != ACCESS) |-> !(avmm_read_o || avmm_write_o));

  a_access_has_strobe: assert property (@(posedge clk) disable iff (reset)
    (state == ACCESS) |-> (avmm_read_o || avmm_write_o));

  a_no_ready_when_busy: assert property (@(posedge clk) disable iff (reset)
    (state != IDLE) |-> !cmd_ready_o);
`endif

endmodule

// File: tb/tb_uart_avmm_master.sv
// Self-checking bench for uart_avmm_master: a reactive slave, a transaction-level
// reference model compared every cycle, and directed scenarios with literal expectations.
module tb_uart_avmm_master;
  localparam int ADDR_W  = 3;
  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 8;
  localparam int HOLD    = 1000;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cmd_valid_i = 1'b0;
  logic              cmd_ready_o;
  logic              cmd_write_i = 1'b0;
  logic [ADDR_W-1:0] cmd_address_i = '0;
  logic [31:0]       cmd_writedata_i = '0;
  logic [3:0]        cmd_byteenable_i = '0;
  logic              rsp_valid_o;
  logic              rsp_write_o;
  logic [31:0]       rsp_readdata_o;
  logic              rsp_timeout_o;
  logic              busy_o;
  logic              avmm_write_o;
  logic              avmm_read_o;
  logic [ADDR_W-1:0] avmm_address_o;
  logic [31:0]       avmm_writedata_o;
  logic [3:0]        avmm_byteenable_o;
  logic              avmm_waitrequest_i = 1'b1;
  logic [31:0]       avmm_readdata_i = 32'hDEAD_BEEF;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  int stall_cfg = 1;

  uart_avmm_master #(
    .ADDR_W(ADDR_W),
    .TIMEOUT_CYCLES(TIMEOUT),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cmd_valid_i(cmd_valid_i),
    .cmd_ready_o(cmd_ready_o),
    .cmd_write_i(cmd_write_i),
    .cmd_address_i(cmd_address_i),
    .cmd_writedata_i(cmd_writedata_i),
    .cmd_byteenable_i(cmd_byteenable_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_write_o(rsp_write_o),
    .rsp_readdata_o(rsp_readdata_o),
    .rsp_timeout_o(rsp_timeout_o),
    .busy_o(busy_o),
    .avmm_write_o(avmm_write_o),
    .avmm_read_o(avmm_read_o),
    .avmm_address_o(avmm_address_o),
    .avmm_writedata_o(avmm_writedata_o),
    .avmm_byteenable_o(avmm_byteenable_o),
    .avmm_waitrequest_i(avmm_waitrequest_i),
    .avmm_readdata_i(avmm_readdata_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks = n_checks + 1;
    if (actual !== expected) begin
      n_fail = n_fail + 1;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Slave: waitrequest high except on strobe cycle stall_cfg+1, where the transfer happens.
  logic [31:0] mem [8] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0000_01A5, 32'h0, 32'h0};
  int strobe_len = 0;

  always @(negedge clk) begin
    if (avmm_read_o || avmm_write_o) strobe_len = strobe_len + 1;
    else strobe_len = 0;
    avmm_waitrequest_i = 1'b1;
    avmm_readdata_i    = 32'hDEAD_BEEF;
    if (strobe_len != 0 && strobe_len == stall_cfg + 1) begin
      avmm_waitrequest_i = 1'b0;
      if (avmm_read_o) avmm_readdata_i = mem[avmm_address_o];
      else begin
        for (int b = 0; b < 4; b++)
          if (avmm_byteenable_o[b]) mem[avmm_address_o][8*b +: 8] = avmm_writedata_o[8*b +: 8];
      end
    end
  end

  // Bus activity monitor for strobe lengths, gaps and response timing.
  int mon_run = 0, mon_low = 0, mon_last_len = 0, mon_last_gap = 0;
  int mon_starts = 0, mon_rsps = 0, mon_rsp_cyc = 0;

  always @(negedge clk) begin
    if (avmm_read_o || avmm_write_o) begin
      if (mon_run == 0) begin
        mon_starts   = mon_starts + 1;
        mon_last_gap = mon_low;
      end
      mon_run = mon_run + 1;
      mon_low = 0;
    end else begin
      if (mon_run != 0) mon_last_len = mon_run;
      mon_run = 0;
      mon_low = mon_low + 1;
    end
    if (rsp_valid_o) begin
      mon_rsps    = mon_rsps + 1;
      mon_rsp_cyc = cyc;
    end
  end

  // Reference model: one outstanding command, tracked by its stall count.
  logic              m_on = 1'b0, m_flight = 1'b0, m_rsp = 1'b0, m_ready = 1'b0;
  logic              m_write = 1'b0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [31:0]       m_wdata = '0;
  logic [3:0]        m_be = '0;
  int                m_stalls = 0;
  logic              m_rsp_write = 1'b0, m_rsp_to = 1'b0;
  logic [31:0]       m_rsp_data = '0;

  always begin
    @(negedge clk);
    #1;
    if (m_on) begin
      checkOutput("cmd_ready", 32'(cmd_ready_o), 32'(m_ready));
      checkOutput("busy", 32'(busy_o), 32'(m_flight || m_rsp));
      checkOutput("write_strobe", 32'(avmm_write_o), 32'(m_flight && m_write));
      checkOutput("read_strobe", 32'(avmm_read_o), 32'(m_flight && !m_write));
      if (m_flight) begin
        checkOutput("avmm_address", 32'(avmm_address_o), 32'(m_addr));
        checkOutput("avmm_writedata", avmm_writedata_o, m_wdata);
        checkOutput("avmm_byteenable", 32'(avmm_byteenable_o), 32'(m_be));
      end
      checkOutput("rsp_valid", 32'(rsp_valid_o), 32'(m_rsp));
      checkOutput("rsp_write", 32'(rsp_write_o), 32'(m_rsp_write));
      checkOutput("rsp_readdata", rsp_readdata_o, m_rsp_data);
      checkOutput("rsp_timeout", 32'(rsp_timeout_o), 32'(m_rsp_to));
    end
    if (reset) begin
      m_on = 1'b1; m_flight = 1'b0; m_rsp = 1'b0; m_ready = 1'b0;
      m_rsp_write = 1'b0; m_rsp_data = '0; m_rsp_to = 1'b0;
    end else if (m_on) begin
      if (m_flight) begin
        if (!avmm_waitrequest_i) begin
          m_flight = 1'b0; m_rsp = 1'b1; m_rsp_write = m_write; m_rsp_to = 1'b0;
          m_rsp_data = m_write ? 32'h0 : avmm_readdata_i;
        end else if (TIMEOUT != 0 && m_stalls == TIMEOUT) begin
          m_flight = 1'b0; m_rsp = 1'b1; m_rsp_write = m_write; m_rsp_to = 1'b1;
          m_rsp_data = 32'h0;
        end else begin
          m_stalls = m_stalls + 1;
        end
      end else if (m_rsp) begin
        m_rsp = 1'b0; m_ready = 1'b1;
      end else if (m_ready && cmd_valid_i) begin
        m_flight = 1'b1; m_ready = 1'b0; m_stalls = 0;
        m_write = cmd_write_i; m_addr = cmd_address_i;
        m_wdata = cmd_write_i ? cmd_writedata_i : 32'h0;
        m_be    = cmd_write_i ? cmd_byteenable_i : 4'hF;
      end else begin
        m_ready = 1'b1;
      end
    end
  end

  // Presents a command and returns just after the accepting edge.
  task automatic applyStimulus(input logic wr, input logic [ADDR_W-1:0] a, input logic [31:0] d,
                               input logic [3:0] be, input bit drop);
    bit accepted = 0;
    cmd_write_i = wr; cmd_address_i = a; cmd_writedata_i = d; cmd_byteenable_i = be;
    cmd_valid_i = 1'b1;
    for (int i = 0; i < 100 && !accepted; i++) begin
      @(negedge clk);
      #1;
      if (cmd_ready_o) begin
        accepted = 1;
        acc_cyc  = cyc;
      end
    end
    checkOutput("cmd_accepted", 32'(accepted), 32'd1);
    @(posedge clk);
    #1;
    if (drop) cmd_valid_i = 1'b0;
  endtask

  task automatic waitRsp();
    bit seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (rsp_valid_o) seen = 1;
    end
    checkOutput("rsp_seen", 32'(seen), 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int starts_before, rsps_before;

  initial begin
    $display("[TB] start");
    idle(3);
    checkOutput("ready_in_reset", 32'(cmd_ready_o), 32'd0);
    reset = 1'b0;
    idle(2);
    checkOutput("ready_after_reset", 32'(cmd_ready_o), 32'd1);

    stall_cfg = 1;
    applyStimulus(1'b1, 3'd0, 32'h0000_0500, 4'h2, 1'b1);
    waitRsp();
    checkOutput("t1_strobe_len", 32'(mon_last_len), 32'd2);
    checkOutput("t1_rsp_latency", 32'(mon_rsp_cyc - acc_cyc), 32'd3);
    checkOutput("t1_rsp_write", 32'(rsp_write_o), 32'd1);
    checkOutput("t1_rsp_timeout", 32'(rsp_timeout_o), 32'd0);
    checkOutput("t1_slave_reg0", mem[0], 32'h0000_0500);

    applyStimulus(1'b1, 3'd1, 32'h0123_0364, 4'hF, 1'b1);
    applyStimulus(1'b0, 3'd1, 32'h0, 4'h0, 1'b1);
    waitRsp();
    checkOutput("t2_readback", rsp_readdata_o, 32'h0123_0364);
    checkOutput("t2_rsp_write", 32'(rsp_write_o), 32'd0);
    checkOutput("t2_strobe_gap", 32'(mon_last_gap), 32'd2);

    stall_cfg = 2;
    applyStimulus(1'b0, 3'd5, 32'h0, 4'h0, 1'b1);
    waitRsp();
    checkOutput("t3_readdata", rsp_readdata_o, 32'h0000_01A5);
    checkOutput("t3_strobe_len", 32'(mon_last_len), 32'd3);
    checkOutput("t3_rsp_latency", 32'(mon_rsp_cyc - acc_cyc), 32'd4);

    stall_cfg = HOLD;
    applyStimulus(1'b0, 3'd1, 32'h0, 4'h0, 1'b1);
    waitRsp();
    checkOutput("t4_timeout_flag", 32'(rsp_timeout_o), 32'd1);
    checkOutput("t4_timeout_data", rsp_readdata_o, 32'h0);
    checkOutput("t4_strobe_len", 32'(mon_last_len), 32'd5);
    checkOutput("t4_rsp_latency", 32'(mon_rsp_cyc - acc_cyc), 32'd6);
    stall_cfg = 1;
    applyStimulus(1'b1, 3'd3, 32'hCAFE_F00D, 4'b0101, 1'b1);
    waitRsp();
    checkOutput("t4_next_timeout", 32'(rsp_timeout_o), 32'd0);
    checkOutput("t4_next_reg3", mem[3], 32'h00FE_000D);

    stall_cfg = TIMEOUT;
    applyStimulus(1'b0, 3'd1, 32'h0, 4'h0, 1'b1);
    waitRsp();
    checkOutput("t5_timeout_flag", 32'(rsp_timeout_o), 32'd0);
    checkOutput("t5_readdata", rsp_readdata_o, 32'h0123_0364);
    checkOutput("t5_strobe_len", 32'(mon_last_len), 32'd5);

    stall_cfg = HOLD;
    starts_before = mon_starts;
    rsps_before   = mon_rsps;
    applyStimulus(1'b1, 3'd6, 32'h0000_0055, 4'hF, 1'b0);
    idle(1);
    reset = 1'b1;
    idle(1);
    checkOutput("t6_strobe_dropped", 32'(avmm_write_o), 32'd0);
    idle(1);
    stall_cfg = 1;
    reset = 1'b0;
    applyStimulus(1'b1, 3'd6, 32'h0000_0055, 4'hF, 1'b1);
    waitRsp();
    idle(6);
    checkOutput("t6_strobe_count", 32'(mon_starts - starts_before), 32'd2);
    checkOutput("t6_rsp_count", 32'(mon_rsps - rsps_before), 32'd1);
    checkOutput("t6_reg6", mem[6], 32'h0000_0055);
    checkOutput("t6_ready_idle", 32'(cmd_ready_o), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
